// File: rtl/decoder_hs.sv
// Registered 4-to-16 one-hot decoder behind a 2-entry skid buffer with valid/ready on both sides.
// One cycle latency when empty; in_ready drops while both entries are held so no code is lost.
module decoder_hs #(
  parameter int IN_W  = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IN_W-1:0]       binary_in,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [(2**IN_W)-1:0]  decoder_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      delivered_cnt
);

  localparam int OUT_W = 2**IN_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             r_state;
  logic [OUT_W-1:0]   r_head;
  logic [OUT_W-1:0]   r_tail;
  logic               r_out_vld;
  logic               r_in_rdy;
  logic [CNT_W-1:0]   r_cnt;

  logic [OUT_W-1:0]   w_dec;
  logic               w_accept;
  logic               w_pop;

  // Words are decoded on the way in, so the buffer only ever holds one-hot or zero.
  always_comb begin
    w_dec = '0;
    if (enable) w_dec[binary_in] = 1'b1;
  end

  assign w_accept = in_valid & r_in_rdy;
  assign w_pop    = r_out_vld & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= EMPTY;
      r_head    <= '0;
      r_tail    <= '0;
      r_out_vld <= 1'b0;
      r_in_rdy  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_pop) r_cnt <= r_cnt + CNT_W'(1);

      unique case (r_state)
        EMPTY: begin
          r_in_rdy <= 1'b1;
          if (w_accept) begin
            r_head    <= w_dec;
            r_out_vld <= 1'b1;
            r_state   <= ONE;
          end
        end
        ONE: begin
          unique case ({w_accept, w_pop})
            2'b11: r_head <= w_dec;
            2'b10: begin
              r_tail   <= w_dec;
              r_in_rdy <= 1'b0;
              r_state  <= FULL;
            end
            2'b01: begin
              // Clear the head so decoder_out reads zero whenever out_valid is low.
              r_head    <= '0;
              r_out_vld <= 1'b0;
              r_state   <= EMPTY;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (w_pop) begin
            r_head   <= r_tail;
            r_tail   <= '0;
            r_in_rdy <= 1'b1;
            r_state  <= ONE;
          end
        end
        default: begin
          r_head    <= '0;
          r_tail    <= '0;
          r_out_vld <= 1'b0;
          r_in_rdy  <= 1'b0;
          r_state   <= EMPTY;
        end
      endcase
    end
  end

  assign in_ready      = r_in_rdy;
  assign out_valid     = r_out_vld;
  assign decoder_out   = r_head;
  assign delivered_cnt = r_cnt;

endmodule

// File: tb/tb_decoder_hs.sv
// Directed bench for decoder_hs: one task per scenario, inline checks, single summary line.
module tb_decoder_hs;

  logic        clk;
  logic        reset;
  logic [3:0]  binary_in;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] decoder_out;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  delivered_cnt;

  int vectors;
  int miscompares;

  decoder_hs #(.IN_W(4), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .binary_in    (binary_in),
    .enable       (enable),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .decoder_out  (decoder_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .delivered_cnt(delivered_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    binary_in = 4'd0;
    enable    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    binary_in = 4'd0;
    enable    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    vectors++;
    if (decoder_out !== 16'h0000) begin miscompares++; $display("FAIL reset_decoder_out got=%h want=0000", decoder_out); end
    vectors++;
    if (delivered_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_cnt got=%0d want=0", delivered_cnt); end
    reset = 1'b0;
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 1'b1; binary_in = 4'd1; enable = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_out_valid got=%b want=1", out_valid); end
    vectors++;
    if (decoder_out !== 16'h0002) begin miscompares++; $display("FAIL single_decoder_out got=%h want=0002", decoder_out); end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain_valid got=%b want=0", out_valid); end
    vectors++;
    if (decoder_out !== 16'h0000) begin miscompares++; $display("FAIL single_drain_out got=%h want=0000", decoder_out); end
    vectors++;
    if (delivered_cnt !== 8'd1) begin miscompares++; $display("FAIL single_cnt got=%0d want=1", delivered_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; binary_in = 4'(i);
      tick();
      exp = 16'h0001 << i;
      vectors++;
      if (out_valid !== 1'b1 || decoder_out !== exp) begin
        miscompares++;
        $display("FAIL b2b_word%0d got=%b/%h want=1/%h", i, out_valid, decoder_out, exp);
      end
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready%0d got=%b want=1", i, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain_valid got=%b want=0", out_valid); end
    vectors++;
    if (delivered_cnt !== 8'd16) begin miscompares++; $display("FAIL b2b_cnt got=%0d want=16", delivered_cnt); end
  endtask

  task automatic test_enable_off();
    do_reset();
    in_valid = 1'b1; binary_in = 4'd7; enable = 1'b0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || decoder_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL en_off_word got=%b/%h want=1/0000", out_valid, decoder_out);
    end
    tick();
    vectors++;
    if (delivered_cnt !== 8'd1) begin miscompares++; $display("FAIL en_off_cnt got=%0d want=1", delivered_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    in_valid = 1'b1; binary_in = 4'd3;
    tick();
    vectors++;
    if (in_ready !== 1'b1 || decoder_out !== 16'h0008) begin
      miscompares++;
      $display("FAIL bp_first got=%b/%h want=1/0008", in_ready, decoder_out);
    end
    binary_in = 4'd5;
    tick();
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full_in_ready got=%b want=0", in_ready); end
    binary_in = 4'd9;
    tick();
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || decoder_out !== 16'h0008) begin
      miscompares++;
      $display("FAIL bp_hold got=%b/%b/%h want=0/1/0008", in_ready, out_valid, decoder_out);
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (decoder_out !== 16'h0008) begin miscompares++; $display("FAIL bp_pop0 got=%h want=0008", decoder_out); end
    tick();
    vectors++;
    if (decoder_out !== 16'h0020 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_pop1 got=%h/%b want=0020/1", decoder_out, in_ready);
    end
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || decoder_out !== 16'h0200) begin
      miscompares++;
      $display("FAIL bp_pop2 got=%b/%h want=1/0200", out_valid, decoder_out);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || delivered_cnt !== 8'd3) begin
      miscompares++;
      $display("FAIL bp_drain got=%b/%0d want=0/3", out_valid, delivered_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; binary_in = 4'd2;
    tick();
    tick();
    out_ready = 1'b0;
    binary_in = 4'd4;
    tick();
    binary_in = 4'd6;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0 || delivered_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL arst_prefill got=%b/%0d want=0/1", in_ready, delivered_cnt);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || decoder_out !== 16'h0000 || in_ready !== 1'b0 || delivered_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL arst_clear got=%b/%h/%b/%0d want=0/0000/0/0", out_valid, decoder_out, in_ready, delivered_cnt);
    end
    #2;
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_release got=%b/%b want=1/0", in_ready, out_valid);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || decoder_out !== 16'h0000 || delivered_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL arst_stale got=%b/%h/%0d want=0/0000/0", out_valid, decoder_out, delivered_cnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; binary_in = 4'(i);
      tick();
    end
    vectors++;
    if (delivered_cnt !== 8'd255) begin miscompares++; $display("FAIL wrap_pre got=%0d want=255", delivered_cnt); end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (delivered_cnt !== 8'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_zero got=%0d/%b want=0/0", delivered_cnt, out_valid);
    end
    in_valid = 1'b1; binary_in = 4'd15;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (decoder_out !== 16'h8000) begin miscompares++; $display("FAIL wrap_word got=%h want=8000", decoder_out); end
    tick();
    vectors++;
    if (delivered_cnt !== 8'd1) begin miscompares++; $display("FAIL wrap_one got=%0d want=1", delivered_cnt); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    binary_in   = 4'd0;
    enable      = 1'b0;
    out_ready   = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_enable_off();
    test_backpressure();
    test_async_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
